// File: rtl/mock_sram_rw_masked.sv
// mock_sram_rw_masked: single-port read/write mock SRAM standing in for large
// cache/data macros. Logical addresses are XOR-folded onto a small physical
// array, writes are granule-masked, reads have a latency of 1 or 2 cycles, and
// contents are scrubbed to zero after every reset so read data is never X.
//
// Ports:
//   RW0_clk    - clock, all state updates on the rising edge
//   reset      - asynchronous active-high reset
//   RW0_addr   - logical address (folded to PHYS_AW bits)
//   RW0_en     - access enable, honoured only once init_done is high
//   RW0_wmode  - 1 = write, 0 = read
//   RW0_wmask  - per-granule write enable
//   RW0_wdata  - write data
//   RW0_rdata  - read data, holds its value between reads
//   init_done  - scrub finished, accesses accepted

// One granule column of the array. Write is synchronous; the read is an
// asynchronous lookup that the top-level read pipeline registers.
module mock_sram_granule #(
   parameter int AW = 4,
   parameter int GW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [GW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [GW-1:0] rdata
);
   logic [GW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

module mock_sram_rw_masked #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 64,
   parameter int MASK_W   = 8,
   parameter int PHYS_AW  = 4,
   parameter int READ_LAT = 1
) (
   input  logic              RW0_clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] RW0_addr,
   input  logic              RW0_en,
   input  logic              RW0_wmode,
   input  logic [MASK_W-1:0] RW0_wmask,
   input  logic [DATA_W-1:0] RW0_wdata,
   output logic [DATA_W-1:0] RW0_rdata,
   output logic              init_done
);
   localparam int GW  = DATA_W / MASK_W;
   localparam int NSL = (ADDR_W + PHYS_AW - 1) / PHYS_AW;

   if (DATA_W % MASK_W != 0) begin : g_chk_mask
      $error("DATA_W must be divisible by MASK_W");
   end
   if (PHYS_AW < 1 || PHYS_AW > ADDR_W) begin : g_chk_paw
      $error("PHYS_AW must be in 1..ADDR_W");
   end
   if (READ_LAT != 1 && READ_LAT != 2) begin : g_chk_lat
      $error("READ_LAT must be 1 or 2");
   end

   typedef enum logic {SCRUB, READY} state_t;

   state_t                       state;
   logic [PHYS_AW-1:0]           scrub_cnt;
   logic [PHYS_AW-1:0]           paddr;
   logic [NSL*PHYS_AW-1:0]       addr_ext;
   logic [PHYS_AW-1:0]           wr_row;
   logic [MASK_W-1:0]            wr_gmask;
   logic [MASK_W-1:0][GW-1:0]    wr_word;
   logic [MASK_W-1:0][GW-1:0]    rd_word;
   logic                         rd_issue;
   logic [DATA_W-1:0]            rdata_q;

   // XOR of PHYS_AW-wide slices; the top slice is zero-extended.
   always_comb begin
      addr_ext = '0;
      addr_ext[ADDR_W-1:0] = RW0_addr;
      paddr = '0;
      for (int s = 0; s < NSL; s++) paddr ^= addr_ext[s*PHYS_AW +: PHYS_AW];
   end

   // Scrub FSM: one zeroed row per cycle, READY after the last row.
   always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
         state     <= SCRUB;
         scrub_cnt <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            SCRUB: begin
               scrub_cnt <= scrub_cnt + 1'b1;
               if (&scrub_cnt) begin
                  state     <= READY;
                  init_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The scrub owns the write port until READY; user accesses are dropped.
   always_comb begin
      wr_row   = paddr;
      wr_gmask = '0;
      wr_word  = RW0_wdata;
      if (state == SCRUB) begin
         wr_row   = scrub_cnt;
         wr_gmask = '1;
         wr_word  = '0;
      end else if (RW0_en && RW0_wmode) begin
         wr_gmask = RW0_wmask;
      end
   end

   assign rd_issue = (state == READY) && RW0_en && !RW0_wmode;

   for (genvar g = 0; g < MASK_W; g++) begin : g_gran
      mock_sram_granule #(.AW(PHYS_AW), .GW(GW)) u_gran (
         .clk   (RW0_clk),
         .we    (wr_gmask[g]),
         .waddr (wr_row),
         .wdata (wr_word[g]),
         .raddr (paddr),
         .rdata (rd_word[g])
      );
   end

   // Read pipeline. Output register only loads when a read completes, so it
   // holds between reads; reset drops anything in flight.
   if (READ_LAT == 2) begin : g_lat2
      logic              vld_pipe;
      logic [DATA_W-1:0] dat_s1;
      always_ff @(posedge RW0_clk or posedge reset) begin
         if (reset) begin
            vld_pipe <= 1'b0;
            dat_s1   <= '0;
            rdata_q  <= '0;
         end else begin
            vld_pipe <= rd_issue;
            if (rd_issue) dat_s1  <= rd_word;
            if (vld_pipe) rdata_q <= dat_s1;
         end
      end
   end else begin : g_lat1
      always_ff @(posedge RW0_clk or posedge reset) begin
         if (reset)         rdata_q <= '0;
         else if (rd_issue) rdata_q <= rd_word;
      end
   end

   assign RW0_rdata = rdata_q;
endmodule
